// File: rtl/point_batch_feeder.sv
// Walks the point memory one query at a time, packing M-point candidate batches
// for validator_core and emitting one inlier/outlier record per query point.
module point_batch_feeder #(
  parameter int unsigned N        = 16,
  parameter int unsigned M        = 32,
  parameter int unsigned AW       = 15,
  parameter int unsigned CORE_LAT = 1   // must be >= 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [AW:0]       cloud_size,
  output logic              mem_rd_en,
  output logic [AW-1:0]     mem_addr,
  input  logic [N-1:0]      mem_x,
  input  logic [N-1:0]      mem_y,
  input  logic [N-1:0]      mem_z,
  output logic [N-1:0]      point_x,
  output logic [N-1:0]      point_y,
  output logic [N-1:0]      point_z,
  output logic              core_reset,
  output logic [N*M-1:0]    cp_x,
  output logic [N*M-1:0]    cp_y,
  output logic [N*M-1:0]    cp_z,
  output logic [M-1:0]      cp_mask,
  output logic              cp_valid,
  input  logic              inlier,
  input  logic              outlier,
  output logic              res_valid,
  output logic [AW-1:0]     res_index,
  output logic              res_inlier,
  output logic              busy,
  output logic              done
);

  localparam int unsigned LW  = $clog2(M + 1);
  localparam int unsigned CLW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
  localparam int unsigned PW  = AW + 1;

  typedef enum logic [2:0] {
    IDLE, LDQ, CRST, FILL, PRES, WAIT, RES, FIN
  } state_t;

  state_t          state;
  logic [PW-1:0]   size_q;
  logic [PW-1:0]   q;
  logic [PW-1:0]   base;
  logic [PW-1:0]   end_q;
  logic [PW-1:0]   next_addr;
  logic [LW-1:0]   lane;
  logic [CLW-1:0]  wait_cnt;
  logic            rd_d1;

  logic            more_c;
  logic            wait_done_c;
  logic            start_fill_c;
  logic [PW-1:0]   fill_base_c;
  logic [PW-1:0]   fill_end_c;

  // Batch sequencing: all bounds are kept in AW+1 bits so a full 2^AW cloud never wraps.
  always_comb begin
    more_c       = (base + PW'(M)) < size_q;
    wait_done_c  = (wait_cnt == CLW'(CORE_LAT - 1));
    start_fill_c = (state == CRST) ||
                   ((state == WAIT) && wait_done_c && !inlier && !outlier && more_c);
    fill_base_c  = (state == CRST) ? '0 : base + PW'(M);
    fill_end_c   = ((fill_base_c + PW'(M)) < size_q) ? fill_base_c + PW'(M) : size_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      size_q     <= '0;
      q          <= '0;
      base       <= '0;
      end_q      <= '0;
      next_addr  <= '0;
      lane       <= '0;
      wait_cnt   <= '0;
      rd_d1      <= 1'b0;
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      point_x    <= '0;
      point_y    <= '0;
      point_z    <= '0;
      core_reset <= 1'b0;
      cp_x       <= '0;
      cp_y       <= '0;
      cp_z       <= '0;
      cp_mask    <= '0;
      cp_valid   <= 1'b0;
      res_valid  <= 1'b0;
      res_index  <= '0;
      res_inlier <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      core_reset <= 1'b0;
      cp_valid   <= 1'b0;
      res_valid  <= 1'b0;
      done       <= 1'b0;
      mem_rd_en  <= 1'b0;
      // Read data is valid the cycle after the strobe; rd_d1 marks that cycle.
      rd_d1      <= mem_rd_en;

      case (state)
        IDLE: begin
          if (start) begin
            size_q <= cloud_size;
            q      <= '0;
            busy   <= 1'b1;
            if (cloud_size == '0) begin
              state <= FIN;
            end else begin
              mem_rd_en <= 1'b1;
              mem_addr  <= '0;
              state     <= LDQ;
            end
          end
        end

        LDQ: begin
          if (rd_d1) begin
            point_x    <= mem_x;
            point_y    <= mem_y;
            point_z    <= mem_z;
            core_reset <= 1'b1;
            state      <= CRST;
          end
        end

        CRST: ;

        FILL: begin
          if (next_addr < end_q) begin
            mem_rd_en <= 1'b1;
            mem_addr  <= next_addr[AW-1:0];
            next_addr <= next_addr + PW'(1);
          end
          if (rd_d1) begin
            for (int k = 0; k < M; k++) begin
              if (lane == LW'(k)) begin
                cp_x[N*(M-k)-1 -: N] <= mem_x;
                cp_y[N*(M-k)-1 -: N] <= mem_y;
                cp_z[N*(M-k)-1 -: N] <= mem_z;
                cp_mask[M-1-k]       <= 1'b1;
              end
            end
            lane <= lane + LW'(1);
            // No read in flight this cycle: this capture completes the batch.
            if (!mem_rd_en) begin
              cp_valid <= 1'b1;
              state    <= PRES;
            end
          end
        end

        PRES: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end

        WAIT: begin
          if (wait_done_c) begin
            if (!start_fill_c) begin
              res_valid  <= 1'b1;
              res_index  <= q[AW-1:0];
              res_inlier <= inlier;
              state      <= RES;
            end
          end else begin
            wait_cnt <= wait_cnt + CLW'(1);
          end
        end

        RES: begin
          if ((q + PW'(1)) == size_q) begin
            state <= FIN;
          end else begin
            q         <= q + PW'(1);
            mem_rd_en <= 1'b1;
            mem_addr  <= AW'(q + PW'(1));
            state     <= LDQ;
          end
        end

        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase

      // Batch launch: clear lanes and issue the first read of the new window.
      if (start_fill_c) begin
        base      <= fill_base_c;
        end_q     <= fill_end_c;
        mem_rd_en <= 1'b1;
        mem_addr  <= fill_base_c[AW-1:0];
        next_addr <= fill_base_c + PW'(1);
        lane      <= '0;
        cp_x      <= '0;
        cp_y      <= '0;
        cp_z      <= '0;
        cp_mask   <= '0;
        state     <= FILL;
      end
    end
  end

endmodule

// File: tb/tb_point_batch_feeder.sv
// Scoreboard bench for point_batch_feeder with M=4: memory holds x=i, y=i+100, z=i+200,
// and a small core model decides per query according to the active mode.
module tb_point_batch_feeder;

  localparam int unsigned N  = 16;
  localparam int unsigned M  = 4;
  localparam int unsigned AW = 15;
  localparam int unsigned CL = 1;

  logic            clock;
  logic            rst_n;
  logic            start;
  logic [AW:0]     cloud_size;
  logic            mem_rd_en;
  logic [AW-1:0]   mem_addr;
  logic [N-1:0]    mem_x, mem_y, mem_z;
  logic [N-1:0]    point_x, point_y, point_z;
  logic            core_reset;
  logic [N*M-1:0]  cp_x, cp_y, cp_z;
  logic [M-1:0]    cp_mask;
  logic            cp_valid;
  logic            inlier, outlier;
  logic            res_valid;
  logic [AW-1:0]   res_index;
  logic            res_inlier;
  logic            busy;
  logic            done;

  point_batch_feeder #(.N(N), .M(M), .AW(AW), .CORE_LAT(CL)) dut (
    .clock(clock), .reset(rst_n), .start(start), .cloud_size(cloud_size),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_x(mem_x), .mem_y(mem_y), .mem_z(mem_z),
    .point_x(point_x), .point_y(point_y), .point_z(point_z),
    .core_reset(core_reset), .cp_x(cp_x), .cp_y(cp_y), .cp_z(cp_z),
    .cp_mask(cp_mask), .cp_valid(cp_valid), .inlier(inlier), .outlier(outlier),
    .res_valid(res_valid), .res_index(res_index), .res_inlier(res_inlier),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic [N*M-1:0] x, y, z;
    logic [M-1:0]   mask;
    logic [N-1:0]   px;
  } batch_t;

  typedef struct {
    logic [AW-1:0] idx;
    logic          inl;
  } res_t;

  batch_t exp_b[$];
  res_t   exp_r[$];

  int tests = 0;
  int fails = 0;
  int done_cnt = 0, rd_cnt = 0, res_cnt = 0, cpv_cnt = 0, cr_total = 0, q3_bad = 0;
  int mode = 0;     // 0 never, 1 inlier on 1st batch, 2 outlier on 2nd batch of q3, 3 both on 1st
  bit watch_q3 = 0;
  int bcnt;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Point memory: registered read, data the cycle after the strobe.
  always @(posedge clock) begin
    if (mem_rd_en) begin
      mem_x <= N'(mem_addr);
      mem_y <= N'(mem_addr + 100);
      mem_z <= N'(mem_addr + 200);
    end
  end

  // Core model: decision one cycle after cp_valid; point_x equals the query index.
  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      inlier  <= 1'b0;
      outlier <= 1'b0;
      bcnt    <= 0;
    end else begin
      inlier  <= 1'b0;
      outlier <= 1'b0;
      if (core_reset) begin
        cr_total <= cr_total + 1;
        bcnt     <= 0;
      end
      if (cp_valid) begin
        bcnt <= bcnt + 1;
        case (mode)
          1: if (bcnt == 0) inlier <= 1'b1;
          2: if (point_x == N'(3) && bcnt == 1) outlier <= 1'b1;
          3: if (bcnt == 0) begin inlier <= 1'b1; outlier <= 1'b1; end
          default: ;
        endcase
      end
    end
  end

  // Monitor: pops expected batches/results whenever the DUT presents one.
  always @(negedge clock) begin
    if (cp_valid) begin
      cpv_cnt++;
      if (exp_b.size() == 0) begin
        chk("unexpected_batch", 256'(cp_x), 256'(0));
        if (cp_x == '0) chk("unexpected_batch", 256'(1), 256'(0));
      end else begin
        batch_t e;
        e = exp_b.pop_front();
        chk("batch", 256'({cp_x, cp_y, cp_z, cp_mask, point_x}),
                     256'({e.x, e.y, e.z, e.mask, e.px}));
      end
    end
    if (res_valid) begin
      res_cnt++;
      if (exp_r.size() == 0) begin
        chk("unexpected_result", 256'({1'b1, res_index, res_inlier}), 256'(0));
      end else begin
        res_t r;
        r = exp_r.pop_front();
        chk("result", 256'({res_index, res_inlier}), 256'({r.idx, r.inl}));
      end
    end
    if (done) done_cnt++;
    if (mem_rd_en) rd_cnt++;
    if (mem_rd_en && watch_q3 && point_x == N'(3) && mem_addr >= AW'(8)) q3_bad++;
  end

  function automatic batch_t mk_batch(input int q, input int first, input int cnt);
    batch_t b;
    b.x = '0; b.y = '0; b.z = '0; b.mask = '0; b.px = N'(q);
    for (int k = 0; k < M; k++) begin
      if (k < cnt) begin
        b.x[N*(M-k)-1 -: N] = N'(first + k);
        b.y[N*(M-k)-1 -: N] = N'(first + k + 100);
        b.z[N*(M-k)-1 -: N] = N'(first + k + 200);
        b.mask[M-1-k]       = 1'b1;
      end
    end
    return b;
  endfunction

  task automatic push_query(input int q, input int nb, input int size, input bit inl);
    res_t r;
    for (int b = 0; b < nb; b++) begin
      int first, cnt;
      first = b * M;
      cnt   = size - first;
      if (cnt > M) cnt = M;
      exp_b.push_back(mk_batch(q, first, cnt));
    end
    r.idx = AW'(q);
    r.inl = inl;
    exp_r.push_back(r);
  endtask

  task automatic pulse_start(input int size);
    @(negedge clock);
    cloud_size = (AW+1)'(size);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic run_pass(input int size, input string nm);
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 0;
    pulse_start(size);
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clock);
      #1;
      seen = (done_cnt > d0);
    end
    chk({nm, "_done_seen"}, 256'(seen), 256'(1));
    repeat (3) @(negedge clock);
    #1;
    chk({nm, "_done_once"}, 256'(done_cnt - d0), 256'(1));
    chk({nm, "_batches_left"}, 256'(exp_b.size()), 256'(0));
    chk({nm, "_results_left"}, 256'(exp_r.size()), 256'(0));
    exp_b.delete();
    exp_r.delete();
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_buses"}, 256'({cp_x, cp_y, cp_z, cp_mask}), 256'(0));
    chk({nm, "_ctrl"}, 256'({mem_rd_en, mem_addr, point_x, point_y, point_z, core_reset,
                             cp_valid, res_valid, res_index, res_inlier, busy, done}), 256'(0));
  endtask

  initial begin
    int c0, p0, r0, rd0, d0;
    bit found;
    rst_n = 1'b0;
    start = 1'b0;
    cloud_size = '0;
    repeat (3) @(negedge clock);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clock);

    // Core never decides: three batches per query, last one half-filled.
    mode = 0;
    for (int q = 0; q < 10; q++) push_query(q, 3, 10, 1'b0);
    run_pass(10, "never");

    // Inlier on first batch: one cp_valid and one core_reset per query.
    mode = 1;
    c0 = cr_total; p0 = cpv_cnt;
    for (int q = 0; q < 10; q++) push_query(q, 1, 10, 1'b1);
    run_pass(10, "inlier1st");
    chk("inlier1st_core_resets", 256'(cr_total - c0), 256'(10));
    chk("inlier1st_cp_valids", 256'(cpv_cnt - p0), 256'(10));

    // Outlier on query 3's second batch cuts that query short.
    mode = 2;
    watch_q3 = 1;
    for (int q = 0; q < 10; q++) push_query(q, (q == 3) ? 2 : 3, 10, 1'b0);
    run_pass(10, "outlier_q3");
    watch_q3 = 0;
    chk("outlier_q3_no_addr8", 256'(q3_bad), 256'(0));

    // Empty cloud: done two cycles after start, no reads, no results.
    mode = 0;
    rd0 = rd_cnt; r0 = res_cnt; d0 = done_cnt;
    pulse_start(0);
    #1;
    chk("empty_cycle1", 256'({busy, done}), 256'(2'b10));
    @(negedge clock); #1;
    chk("empty_cycle2", 256'({busy, done}), 256'(2'b01));
    @(negedge clock); #1;
    chk("empty_cycle3", 256'({busy, done}), 256'(2'b00));
    repeat (3) @(negedge clock);
    #1;
    chk("empty_no_reads", 256'(rd_cnt - rd0), 256'(0));
    chk("empty_no_results", 256'(res_cnt - r0), 256'(0));
    chk("empty_one_done", 256'(done_cnt - d0), 256'(1));

    // Both flags set: inlier wins; cloud of 3 leaves lane 3 empty.
    mode = 3;
    for (int q = 0; q < 3; q++) push_query(q, 1, 3, 1'b1);
    run_pass(3, "both_flags");

    // Reset during FILL of query 5 aborts the pass; a fresh pass follows.
    mode = 0;
    for (int q = 0; q < 5; q++) push_query(q, 3, 10, 1'b0);
    r0 = res_cnt; d0 = done_cnt;
    pulse_start(10);
    found = 0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge clock);
      #1;
      found = (point_x == N'(5)) && mem_rd_en;
    end
    chk("abort_reached_q5_fill", 256'(found), 256'(1));
    rst_n = 1'b0;
    #2;
    chk_all_zero("abort_reset");
    repeat (2) @(negedge clock);
    chk("abort_results", 256'(res_cnt - r0), 256'(5));
    chk("abort_no_done", 256'(done_cnt - d0), 256'(0));
    chk("abort_batches_left", 256'(exp_b.size()), 256'(0));
    chk("abort_results_left", 256'(exp_r.size()), 256'(0));
    exp_b.delete();
    exp_r.delete();
    rst_n = 1'b1;
    @(negedge clock);
    r0 = res_cnt;
    for (int q = 0; q < 4; q++) push_query(q, 1, 4, 1'b0);
    run_pass(4, "after_abort");
    chk("after_abort_results", 256'(res_cnt - r0), 256'(4));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/point_batch_feeder.md
Name: point_batch_feeder

Overview:
- Upstream stage of validator_core: walks a point-cloud memory one query point at a time.
- For each query: holds the query coordinates, pulses the core's reset, then packs successive groups of M candidate points into the cp_x/cp_y/cp_z buses and presents one batch per handshake.
- Stops a query early as soon as the core flags inlier or outlier, then emits a per-point result record for the downstream inlier writer.

Parameters:
- N, 16, coordinate width in bits.
- M, 32, candidate points per batch (lanes).
- AW, 15, point-memory address width.
- CORE_LAT, 1, cycles from cp_valid to a valid inlier/outlier sample.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a full pass when idle.
- cloud_size  in  AW+1  number of points in memory (0..2^AW); sampled on start.
- mem_rd_en  out  1  point-memory read strobe.
- mem_addr  out  AW  read address.
- mem_x, mem_y, mem_z  in  N each  read data, valid exactly 1 cycle after mem_rd_en.
- point_x, point_y, point_z  out  N each  current query point to core.
- core_reset  out  1  active-high one-cycle pulse to validator_core reset.
- cp_x, cp_y, cp_z  out  N*M each  packed candidates; first-read point in bits [N*M-1 -: N], lane k at [N*(M-k)-1 -: N].
- cp_mask  out  M  lane valid bits; bit M-1-k set if lane k holds a real point.
- cp_valid  out  1  one-cycle strobe: batch stable and valid.
- inlier, outlier  in  1 each  core decision.
- res_valid  out  1  one-cycle result strobe.
- res_index  out  AW  query index of result.
- res_inlier  out  1  1 = inlier, 0 = outlier or undecided.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse after the last result.

Behaviour:
- Reset (reset=0, async): state IDLE. All outputs 0, including the cp buses and mask. Query index and batch base are 0.
- FSM states: IDLE, LDQ, CRST, FILL, PRES, WAIT, RES, FIN.
- IDLE: start=1 with cloud_size>0 goes to LDQ with q=0. start with cloud_size=0 goes directly to FIN (done pulse, no results). start is ignored when not IDLE.
- LDQ: mem_rd_en=1, mem_addr=q for one cycle. Next cycle latch point_x/y/z from mem_*.
- CRST: core_reset=1 for exactly one cycle; base=0.
- FILL: issue reads base..min(base+M, cloud_size)-1 on consecutive cycles. Each returned datum lands in the next lane, one cycle after its read. Lanes beyond the end are zeroed with the mask bit cleared. cp buses clear at FILL entry. FILL lasts (lanes issued)+1 cycles.
- PRES: cp_valid=1 for one cycle. cp buses and mask hold until the next FILL entry.
- WAIT: count CORE_LAT cycles, then sample inlier/outlier.
  - Either flag high: go to RES with the flag.
  - Neither flag and base+M < cloud_size: base += M, go to FILL.
  - Neither flag and batches exhausted: go to RES with res_inlier=0.
  - Both flags high: inlier wins.
- RES: res_valid=1, res_index=q. If q+1 == cloud_size go to FIN, else q++ and go to LDQ.
- FIN: done=1 one cycle, busy drops the same cycle, then IDLE.
- Address arithmetic: base and end comparisons are done in AW+1 bits; no wrap at 2^AW.
- Query point is included among its own candidates; the core handles self-match.
- Async reset mid-pass aborts immediately. No res_valid or done is produced for the aborted pass.
- Per-batch cost: lanes+1 (FILL) + 1 (PRES) + CORE_LAT cycles. Per-query overhead: 2 (LDQ) + 1 (CRST) + 1 (RES).

Test Plan:
- M=4, CORE_LAT=1, cloud_size=10, mem x=index (0..9), core model never decides:
  - each query sees 3 batches.
  - cp_x lanes are {0,1,2,3}, {4,5,6,7}, {8,9,0,0}, with cp_mask 1111, 1111, 1100.
  - 10 results with res_inlier=0, indices 0..9, then one done pulse.
- Same setup, core asserts inlier on the 1st cp_valid of each query: exactly one cp_valid per query; res_inlier=1; core_reset pulses 10 times.
- Core asserts outlier on the 2nd batch for query 3: res_index=3, res_inlier=0; no third batch for query 3 (mem_addr never reaches 8 for that query).
- cloud_size=0 then start: done pulses 2 cycles after start; no mem_rd_en and no res_valid.
- Inlier and outlier both high at the sample: res_inlier=1.
- Pull reset low during FILL of query 5, release, then start with cloud_size=4: all outputs read 0 during reset; new pass yields results 0..3 only.
